demux32_1to3_buf: RTL and testbench
===================================

DEMUX32_1TO3_BUF -- requirements
Module: demux32_1to3_buf

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port in_valid, input, 1 bit: upstream word present.
REQ-004 SHALL have port in_data, input, 32 bits: word to route.
REQ-005 SHALL have port in_sel, input, 2 bits: destination, 0/1/2 valid, 3 illegal.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts the word this cycle.
REQ-007 SHALL have port out_ready, input, 3 bits: bit i high means consumer i takes its word.
REQ-008 SHALL have port out_valid, output, 3 bits: bit i high means out_data_i holds a word.
REQ-009 SHALL have ports out_data_0, out_data_1, out_data_2, output, 32 bits each: per-destination holding registers.
REQ-010 SHALL have port err_sel, output, 1 bit: one-cycle pulse for each accepted word with in_sel==3.
REQ-011 SHALL have port drop_cnt, output, 8 bits: count of accepted words with in_sel==3.

Function
REQ-012 SHALL keep one slot per destination i, with two states: EMPTY (out_valid[i]=0) and FULL (out_valid[i]=1).
REQ-013 SHALL define input acceptance as in_valid & in_ready at a rising clk edge.
REQ-014 SHALL define delivery on output i as out_valid[i] & out_ready[i] at a rising clk edge.
REQ-015 SHALL drive in_ready combinationally as follows:
- in_sel==3: 1.
- otherwise: 1 when slot in_sel is EMPTY, or is FULL with out_ready[in_sel]=1.
REQ-016 SHALL make in_ready independent of in_valid.
REQ-017 SHALL, on acceptance with in_sel=i (i<3), load out_data_i with in_data and set slot i FULL at that edge (latency 1 cycle).
REQ-018 SHALL, on delivery from slot i without a same-edge load into i, set slot i EMPTY.
REQ-019 SHALL hold out_data_i unchanged when no load into slot i occurs; out_data_i keeps its stale value after delivery.
REQ-020 SHALL, on same-edge delivery from and load into slot i, keep slot i FULL, show the new word next cycle, and lose no word.
REQ-021 SHALL keep out_data_i constant while out_valid[i]=1 and out_ready[i]=0 (no overwrite when full and stalled).
REQ-022 SHALL ignore out_ready[i] while slot i is EMPTY.
REQ-023 SHALL leave the other slots unaffected by a load or delivery on slot i; all three outputs drain independently in the same cycle.
REQ-024 SHALL, on acceptance with in_sel==3, discard the word, assert err_sel for exactly the next cycle, and increment drop_cnt.
REQ-025 SHALL saturate drop_cnt at 255 with no wrap.
REQ-026 SHALL pulse err_sel high on each of back-to-back illegal acceptances, so it stays high continuously.
REQ-027 SHALL change no state when in_valid=0, other than deliveries.

Reset
REQ-028 SHALL, while rst_n=0, immediately force these values regardless of clk:
- out_valid=3'b000
- out_data_0/1/2=32'h0
- err_sel=0
- drop_cnt=0
REQ-029 SHALL discard words held in slots when reset is asserted mid-operation; no delivery is reported for them.
REQ-030 SHALL accept the first word at the first rising clk edge after rst_n deasserts.
REQ-031 SHALL drive in_ready=1 during and after reset, since all slots are EMPTY.

Verification
REQ-032 SHALL cover basic route: in_sel=1, in_data=32'hDEADBEEF, out_ready=3'b111 -> next cycle out_valid=3'b010 and out_data_1=32'hDEADBEEF; one cycle later out_valid=3'b000.
REQ-033 SHALL cover stall and backpressure: out_ready=0, send 32'h11 then 32'h22 to slot 0 -> in_ready=0 on the second word; out_data_0 stays 32'h11; after out_ready[0]=1 for one edge, 32'h22 is accepted on that same edge and appears next cycle.
REQ-034 SHALL cover simultaneous drain and refill: slot 2 FULL with 32'hA, out_ready[2]=1, new word 32'hB to slot 2 on the same edge -> out_valid[2] stays 1, out_data_2=32'hB, and exactly two deliveries are counted.
REQ-035 SHALL cover illegal select: 300 consecutive words with in_sel=3 -> in_ready=1 throughout, err_sel high for 300 cycles, drop_cnt ends at 255, out_valid=3'b000.
REQ-036 SHALL cover reset mid-operation: all slots FULL and drop_cnt=5, pulse rst_n low between clk edges -> all outputs read zero immediately; after release, a word to slot 0 is accepted on the first edge.
REQ-037 SHALL cover parallel drain: load slots 0, 1, 2 on three cycles, then out_ready=3'b111 -> all three delivered on one edge, each with its own data intact.

Source files
------------

// File: rtl/demux32_1to3_buf.sv
// One-to-three demultiplexer with a single-entry holding slot per destination.
// Illegal selects are dropped, flagged with a one-cycle pulse and counted.
module demux32_1to3_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic [1:0]  in_sel,
    output logic        in_ready,
    input  logic [2:0]  out_ready,
    output logic [2:0]  out_valid,
    output logic [31:0] out_data_0,
    output logic [31:0] out_data_1,
    output logic [31:0] out_data_2,
    output logic        err_sel,
    output logic [7:0]  drop_cnt
);

    logic [2:0]  out_valid_r;
    logic [31:0] data_r [3];
    logic        err_sel_r;
    logic [7:0]  drop_cnt_r;

    logic        in_ready_s;
    logic        accept_s;
    logic        illegal_s;
    logic [2:0]  sel_onehot_s;
    logic [2:0]  load_s;
    logic [2:0]  deliver_s;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

    // Ready: an illegal word is always sunk; a legal one needs its slot free or draining.
    always_comb begin
        in_ready_s = 1'b1;
        case (in_sel)
            2'd0:    in_ready_s = !out_valid_r[0] || out_ready[0];
            2'd1:    in_ready_s = !out_valid_r[1] || out_ready[1];
            2'd2:    in_ready_s = !out_valid_r[2] || out_ready[2];
            2'd3:    in_ready_s = 1'b1;
            default: in_ready_s = 1'b1;
        endcase
    end

    // Destination decode of the select field.
    always_comb begin
        sel_onehot_s = 3'b000;
        case (in_sel)
            2'd0:    sel_onehot_s = 3'b001;
            2'd1:    sel_onehot_s = 3'b010;
            2'd2:    sel_onehot_s = 3'b100;
            2'd3:    sel_onehot_s = 3'b000;
            default: sel_onehot_s = 3'b000;
        endcase
    end

    // Handshake qualification for loads, drops and deliveries.
    always_comb begin
        accept_s  = in_valid && in_ready_s;
        load_s    = {3{accept_s}} & sel_onehot_s;
        illegal_s = accept_s && (in_sel == 2'd3);
        deliver_s = out_valid_r & out_ready;
    end

    // Slot occupancy: a same-edge load wins over delivery so the slot stays full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (load_s[i]) begin
                    out_valid_r[i] <= 1'b1;
                end else if (deliver_s[i]) begin
                    out_valid_r[i] <= 1'b0;
                end else begin
                    out_valid_r[i] <= out_valid_r[i];
                end
            end
        end
    end

    // Slot data: written only on a load; otherwise retains its (possibly stale) word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                data_r[i] <= 32'h0000_0000;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (load_s[i]) begin
                    data_r[i] <= in_data;
                end else begin
                    data_r[i] <= data_r[i];
                end
            end
        end
    end

    // Illegal-select pulse and saturating drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sel_r  <= 1'b0;
            drop_cnt_r <= 8'd0;
        end else begin
            err_sel_r <= illegal_s;
            if (illegal_s) begin
                drop_cnt_r <= sat_inc8(drop_cnt_r);
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_r;
    assign out_data_0 = data_r[0];
    assign out_data_1 = data_r[1];
    assign out_data_2 = data_r[2];
    assign err_sel    = err_sel_r;
    assign drop_cnt   = drop_cnt_r;

endmodule

// File: tb/tb_demux32_1to3_buf.sv
// Directed bench for demux32_1to3_buf: routing, backpressure, drain/refill,
// illegal selects with saturation, and asynchronous mid-operation reset.
module tb_demux32_1to3_buf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic [1:0]  in_sel;
    logic        in_ready;
    logic [2:0]  out_ready;
    logic [2:0]  out_valid;
    logic [31:0] out_data_0;
    logic [31:0] out_data_1;
    logic [31:0] out_data_2;
    logic        err_sel;
    logic [7:0]  drop_cnt;

    int n_vec  = 0;
    int n_miss = 0;
    int dlv2   = 0;
    int dlv2_base;

    demux32_1to3_buf dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_ready   (in_ready),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data_0 (out_data_0),
        .out_data_1 (out_data_1),
        .out_data_2 (out_data_2),
        .err_sel    (err_sel),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    // Bench-side count of deliveries observed on output 2.
    always @(posedge clk) begin
        if (out_valid[2] && out_ready[2]) dlv2 <= dlv2 + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] sel, input logic [31:0] data);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = data;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        in_sel    = 2'd0;
        out_ready = 3'b000;
        #3;
        check("rst_valid", {29'd0, out_valid}, 32'd0);
        check("rst_d0", out_data_0, 32'h0);
        check("rst_d1", out_data_1, 32'h0);
        check("rst_d2", out_data_2, 32'h0);
        check("rst_err", {31'd0, err_sel}, 32'd0);
        check("rst_drop", {24'd0, drop_cnt}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        #9 rst_n = 1'b1;

        // Basic route to slot 1
        send(2'd1, 32'hDEADBEEF);
        out_ready = 3'b111;
        check("route_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        check("route_valid", {29'd0, out_valid}, 32'h2);
        check("route_d1", out_data_1, 32'hDEADBEEF);
        step();
        check("route_drain", {29'd0, out_valid}, 32'h0);
        check("route_stale", out_data_1, 32'hDEADBEEF);

        // Stall and backpressure on slot 0
        out_ready = 3'b000;
        send(2'd0, 32'h11);
        step();
        check("stall_v1", {29'd0, out_valid}, 32'h1);
        send(2'd0, 32'h22);
        check("stall_notready", {31'd0, in_ready}, 32'd0);
        step();
        check("stall_hold", out_data_0, 32'h11);
        check("stall_v2", {29'd0, out_valid}, 32'h1);
        out_ready = 3'b001;
        check("stall_release", {31'd0, in_ready}, 32'd1);
        step();
        in_valid  = 1'b0;
        out_ready = 3'b000;
        check("stall_new", out_data_0, 32'h22);
        check("stall_v3", {29'd0, out_valid}, 32'h1);
        out_ready = 3'b001;
        step();
        check("stall_empty", {29'd0, out_valid}, 32'h0);

        // Simultaneous drain and refill on slot 2
        dlv2_base = dlv2;
        out_ready = 3'b000;
        send(2'd2, 32'hA);
        step();
        send(2'd2, 32'hB);
        out_ready = 3'b100;
        check("refill_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        check("refill_valid", {29'd0, out_valid}, 32'h4);
        check("refill_d2", out_data_2, 32'hB);
        step();
        check("refill_empty", {29'd0, out_valid}, 32'h0);
        check("refill_dlv", dlv2 - dlv2_base, 32'd2);

        // Parallel drain of all three slots
        out_ready = 3'b000;
        send(2'd0, 32'h1000_0000); step();
        send(2'd1, 32'h2000_0000); step();
        send(2'd2, 32'h3000_0000); step();
        in_valid = 1'b0;
        check("par_full", {29'd0, out_valid}, 32'h7);
        out_ready = 3'b111;
        step();
        check("par_empty", {29'd0, out_valid}, 32'h0);
        check("par_d0", out_data_0, 32'h1000_0000);
        check("par_d1", out_data_1, 32'h2000_0000);
        check("par_d2", out_data_2, 32'h3000_0000);

        // 300 illegal selects: continuous err_sel, drop_cnt saturates at 255
        out_ready = 3'b000;
        for (int i = 0; i < 300; i++) begin
            send(2'd3, i);
            check("ill_ready", {31'd0, in_ready}, 32'd1);
            step();
            check("ill_err", {31'd0, err_sel}, 32'd1);
            if (i == 254) check("ill_sat", {24'd0, drop_cnt}, 32'd255);
        end
        in_valid = 1'b0;
        check("ill_drop", {24'd0, drop_cnt}, 32'd255);
        check("ill_valid", {29'd0, out_valid}, 32'h0);
        step();
        check("ill_err_off", {31'd0, err_sel}, 32'd0);

        // Reset mid-operation: clear, build drop_cnt=5 and fill all slots, then pulse reset
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        check("clr_drop", {24'd0, drop_cnt}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            send(2'd3, 32'hFFFF_0000);
            step();
        end
        send(2'd0, 32'hC0); step();
        send(2'd1, 32'hC1); step();
        send(2'd2, 32'hC2); step();
        check("mid_drop5", {24'd0, drop_cnt}, 32'd5);
        check("mid_full", {29'd0, out_valid}, 32'h7);
        send(2'd0, 32'h5A5A_5A5A);
        rst_n = 1'b0;
        #2;
        check("mid_valid", {29'd0, out_valid}, 32'h0);
        check("mid_d0", out_data_0, 32'h0);
        check("mid_d1", out_data_1, 32'h0);
        check("mid_d2", out_data_2, 32'h0);
        check("mid_err", {31'd0, err_sel}, 32'd0);
        check("mid_drop", {24'd0, drop_cnt}, 32'd0);
        check("mid_ready", {31'd0, in_ready}, 32'd1);
        #1 rst_n = 1'b1;
        step();
        in_valid = 1'b0;
        check("post_valid", {29'd0, out_valid}, 32'h1);
        check("post_d0", out_data_0, 32'h5A5A_5A5A);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
